// File: rtl/vect_exec_unit.sv
// vect_exec_unit: lane-wise vector execute stage with lane-serial MUL/MAC.
// Optional feature macro VECT_SAT_EN: saturating two's-complement ADD/SUB.
// Ports: clk; reset (sync, active-low); valid_in/ctrl_in/vect1/vect2/vect3 op from ID/EX;
//        stall holds upstream while BUSY; valid_out/ctrl_out/result/zero feed EX/WB.
module vect_exec_unit #(
    parameter int WIDTH        = 8,
    parameter int registerSize = 16,
    parameter int vectorSize   = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   valid_in,
    input  logic [WIDTH-1:0]                       ctrl_in,
    input  logic [vectorSize-1:0][registerSize-1:0] vect1,
    input  logic [vectorSize-1:0][registerSize-1:0] vect2,
    input  logic [vectorSize-1:0][registerSize-1:0] vect3,
    output logic                                   stall,
    output logic                                   valid_out,
    output logic [WIDTH-1:0]                       ctrl_out,
    output logic [vectorSize-1:0][registerSize-1:0] result,
    output logic                                   zero
);
    localparam int RS = registerSize;
    localparam int CW = $clog2(vectorSize);
    typedef logic [vectorSize-1:0][RS-1:0] vec_t;
    typedef enum logic {IDLE, BUSY} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    vec_t             a_q, b_q, c_q, res_q, res_d, alu;
    logic [WIDTH-1:0] ctrl_q;
    logic             valid_q, valid_d, zero_q, zero_d, accept, is_mul;
    logic [RS-1:0]    prod;
    logic [2:0]       op;
    assign op     = ctrl_in[2:0];
    assign is_mul = op[2:1] == 2'b01;
    assign accept = valid_in && state_q == IDLE;
    for (genvar g = 0; g < vectorSize; g++) begin : g_lane
        logic [RS-1:0] add, sub;
`ifdef VECT_SAT_EN
        logic [RS:0] s, d;
        assign s   = {vect1[g][RS-1], vect1[g]} + {vect2[g][RS-1], vect2[g]};
        assign d   = {vect1[g][RS-1], vect1[g]} - {vect2[g][RS-1], vect2[g]};
        // sign bit disagreeing with the extension bit means overflow; clamp toward the true sign
        assign add = (s[RS] ^ s[RS-1]) ? {s[RS], {(RS-1){~s[RS]}}} : s[RS-1:0];
        assign sub = (d[RS] ^ d[RS-1]) ? {d[RS], {(RS-1){~d[RS]}}} : d[RS-1:0];
`else
        assign add = vect1[g] + vect2[g];
        assign sub = vect1[g] - vect2[g];
`endif
        assign alu[g] = op == 3'd0 ? add :
                        op == 3'd1 ? sub :
                        op == 3'd4 ? vect1[g] & vect2[g] :
                        op == 3'd5 ? vect1[g] | vect2[g] :
                        op == 3'd6 ? vect1[g] ^ vect2[g] : vect3[g];
    end
    // single shared multiplier walks the captured operands one lane per cycle
    assign prod = a_q[cnt_q] * b_q[cnt_q] + (ctrl_q[0] ? c_q[cnt_q] : '0);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        valid_d = 1'b0;
        zero_d  = zero_q;
        if (state_q == BUSY) begin
            res_d[cnt_q] = prod;
            cnt_d        = cnt_q + CW'(1);
            if (cnt_q == CW'(vectorSize - 1)) begin
                state_d = IDLE;
                valid_d = 1'b1;
                zero_d  = res_d == '0;
            end
        end else if (valid_in) begin
            if (is_mul) begin
                state_d = BUSY;
                cnt_d   = '0;
            end else begin
                res_d   = alu;
                valid_d = 1'b1;
                zero_d  = alu == '0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            zero_q  <= 1'b0;
            ctrl_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            zero_q  <= zero_d;
            if (accept) begin
                ctrl_q <= ctrl_in;
                a_q    <= vect1;
                b_q    <= vect2;
                c_q    <= vect3;
            end
        end
    end
    assign stall     = state_q == BUSY;
    assign valid_out = valid_q;
    assign ctrl_out  = ctrl_q;
    assign result    = res_q;
    assign zero      = zero_q;
endmodule
